cond_exec_seq: RTL and testbench

- Multicycle conditional-execution sequencer for the ARM core.
- Owns the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against it. Sequences the instruction through evaluate/execute/commit and gates its architectural write enables (register file, memory, PC) so that failed-condition instructions retire with no side effects.
- Sits between the instruction decoder (issue side) and the datapath write ports/ALU flag outputs.

---
 rtl/cond_exec_seq.sv | 135 +++++++++++++
 tb/tb_cond_exec_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_seq.sv
// Conditional-execution sequencer: owns NZCV, evaluates the condition field and
// steps each instruction through EVAL/EXEC/COMMIT, gating its write enables.
module cond_exec_seq #(
  parameter int         CYC_W     = 3,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       cond,
  input  logic [1:0]       flag_w,
  input  logic             reg_w_req,
  input  logic             mem_w_req,
  input  logic             pcs_req,
  input  logic [CYC_W-1:0] exec_cycles,
  input  logic [3:0]       alu_flags,
  input  logic             flush,
  output logic             reg_write,
  output logic             mem_write,
  output logic             pc_src,
  output logic [3:0]       flags,
  output logic             done,
  output logic             executed,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, EVAL, EXEC, COMMIT} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cond_q;
  logic [1:0]       flag_w_q;
  logic             reg_q, mem_q, pcs_q;
  logic [CYC_W-1:0] cnt;
  logic             cond_ex;
  logic             accept, last_exec, commit_d;
  logic             reg_write_d, mem_write_d, pc_src_d, done_d, executed_d, illegal_d;
  logic [3:0]       flags_d;

  // Condition pairs share the test; the low bit inverts it. 1111 never passes.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, p;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    p = z;
      3'd1:    p = cy;
      3'd2:    p = n;
      3'd3:    p = v;
      3'd4:    p = cy & ~z;
      3'd5:    p = (n == v);
      3'd6:    p = ~z & (n == v);
      default: p = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? ~p : p;
  endfunction

  assign accept    = issue_valid & issue_ready;
  assign last_exec = (state == EXEC) & ~flush & (cnt == CYC_W'(1));

  // state register plus captured instruction fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cond_q   <= 4'b0;
      flag_w_q <= 2'b0;
      reg_q    <= 1'b0;
      mem_q    <= 1'b0;
      pcs_q    <= 1'b0;
      cnt      <= '0;
      cond_ex  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cond_q   <= cond;
        flag_w_q <= flag_w;
        reg_q    <= reg_w_req;
        mem_q    <= mem_w_req;
        pcs_q    <= pcs_req;
        cnt      <= (exec_cycles == '0) ? CYC_W'(1) : exec_cycles;
      end
      if (state == EVAL) cond_ex <= cond_pass(cond_q, flags);
      if (state == EXEC && cnt != CYC_W'(1)) cnt <= cnt - CYC_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EVAL;
      EVAL:    state_nxt = flush ? IDLE : EXEC;
      EXEC:    if (flush) state_nxt = IDLE;
               else if (cnt == CYC_W'(1)) state_nxt = COMMIT;
      default: state_nxt = IDLE;
    endcase
  end

  // next values of the registered outputs; they land on entry to COMMIT
  always_comb begin
    issue_ready = (state == IDLE) & ~flush;
    commit_d    = last_exec;
    reg_write_d = commit_d & reg_q & cond_ex;
    mem_write_d = commit_d & mem_q & cond_ex;
    pc_src_d    = commit_d & pcs_q & cond_ex;
    done_d      = commit_d;
    executed_d  = commit_d & cond_ex;
    illegal_d   = commit_d & (cond_q == 4'b1111);
    flags_d     = flags;
    if (commit_d && cond_ex) begin
      if (flag_w_q[1]) flags_d[3:2] = alu_flags[3:2];
      if (flag_w_q[0]) flags_d[1:0] = alu_flags[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags     <= FLAGS_RST;
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      pc_src    <= 1'b0;
      done      <= 1'b0;
      executed  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      flags     <= flags_d;
      reg_write <= reg_write_d;
      mem_write <= mem_write_d;
      pc_src    <= pc_src_d;
      done      <= done_d;
      executed  <= executed_d;
      illegal   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_cond_exec_seq.sv
// Directed bench for cond_exec_seq: vector table of single instructions plus
// hand sequences for flush, reset and back-to-back issue.
module tb_cond_exec_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_ready;
  logic [3:0] cond;
  logic [1:0] flag_w;
  logic       reg_w_req, mem_w_req, pcs_req;
  logic [2:0] exec_cycles;
  logic [3:0] alu_flags;
  logic       flush;
  logic       reg_write, mem_write, pc_src, done, executed, illegal;
  logic [3:0] flags;

  int applied = 0;
  int miscompares = 0;

  cond_exec_seq dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .cond(cond), .flag_w(flag_w), .reg_w_req(reg_w_req), .mem_w_req(mem_w_req),
    .pcs_req(pcs_req), .exec_cycles(exec_cycles), .alu_flags(alu_flags), .flush(flush),
    .reg_write(reg_write), .mem_write(mem_write), .pc_src(pc_src), .flags(flags),
    .done(done), .executed(executed), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cond;
    logic [1:0] fw;
    logic       rq, mq, pq;
    logic [2:0] ncyc;
    logic [3:0] alu;
    logic       ex, ill;
    logic [3:0] flg;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 0; cond = 0; flag_w = 0; reg_w_req = 0; mem_w_req = 0;
    pcs_req = 0; exec_cycles = 0; alu_flags = 0; flush = 0;
  endtask

  // Waits for ready at a negedge; returns with the instruction accepted on the
  // next posedge and the bench sitting at the negedge of cycle 1.
  task automatic issue(input vec_t v);
    int k;
    k = 0;
    while (!issue_ready && k < 20) begin @(negedge clk); k++; end
    if (k >= 20) chk("ready_timeout", 8'(issue_ready), 8'd1);
    cond = v.cond; flag_w = v.fw; reg_w_req = v.rq; mem_w_req = v.mq;
    pcs_req = v.pq; exec_cycles = v.ncyc; alu_flags = v.alu; issue_valid = 1;
    @(negedge clk);
    issue_valid = 0;
    cond = ~v.cond; flag_w = ~v.fw; reg_w_req = ~v.rq; mem_w_req = ~v.mq;
    pcs_req = ~v.pq; exec_cycles = ~v.ncyc;
  endtask

  task automatic run(input int idx, input vec_t v);
    int k, neff;
    logic stray;
    neff  = (v.ncyc == 0) ? 1 : int'(v.ncyc);
    stray = 0;
    issue(v);
    k = 1;
    while (!done && k <= 20) begin
      stray |= reg_write | mem_write | pc_src | executed | illegal;
      @(negedge clk);
      k++;
    end
    chk($sformatf("v%0d_latency", idx), 8'(k), 8'(2 + neff));
    chk($sformatf("v%0d_stray", idx), 8'(stray), 8'd0);
    chk($sformatf("v%0d_executed", idx), 8'(executed), 8'(v.ex));
    chk($sformatf("v%0d_reg_write", idx), 8'(reg_write), 8'(v.rq & v.ex));
    chk($sformatf("v%0d_mem_write", idx), 8'(mem_write), 8'(v.mq & v.ex));
    chk($sformatf("v%0d_pc_src", idx), 8'(pc_src), 8'(v.pq & v.ex));
    chk($sformatf("v%0d_illegal", idx), 8'(illegal), 8'(v.ill));
    chk($sformatf("v%0d_flags", idx), 8'(flags), 8'(v.flg));
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), 8'(done | reg_write | mem_write | pc_src), 8'd0);
    idle_inputs();
  endtask

  function automatic vec_t mk(logic [3:0] c, logic [1:0] fw, logic rq, logic mq, logic pq,
                              logic [2:0] n, logic [3:0] alu, logic ex, logic ill, logic [3:0] flg);
    vec_t v;
    v.cond = c; v.fw = fw; v.rq = rq; v.mq = mq; v.pq = pq;
    v.ncyc = n; v.alu = alu; v.ex = ex; v.ill = ill; v.flg = flg;
    return v;
  endfunction

  initial begin
    int acc[$];
    int k;
    vec_t v;
    logic seen;

    //           cond    fw     rq mq pq n     alu     ex ill flags after
    tbl[0]  = mk(4'hE, 2'b11, 1, 0, 0, 3'd1, 4'b0100, 1, 0, 4'b0100);
    tbl[1]  = mk(4'h0, 2'b00, 0, 1, 0, 3'd1, 4'b0000, 1, 0, 4'b0100);
    tbl[2]  = mk(4'h1, 2'b11, 0, 1, 0, 3'd1, 4'b1000, 0, 0, 4'b0100);
    tbl[3]  = mk(4'hE, 2'b11, 0, 0, 1, 3'd2, 4'b1001, 1, 0, 4'b1001);
    tbl[4]  = mk(4'hA, 2'b00, 1, 0, 0, 3'd1, 4'b0000, 1, 0, 4'b1001);
    tbl[5]  = mk(4'hB, 2'b00, 1, 0, 0, 3'd1, 4'b0000, 0, 0, 4'b1001);
    tbl[6]  = mk(4'hC, 2'b00, 1, 0, 0, 3'd1, 4'b0000, 1, 0, 4'b1001);
    tbl[7]  = mk(4'hE, 2'b11, 0, 0, 0, 3'd3, 4'b1101, 1, 0, 4'b1101);
    tbl[8]  = mk(4'hC, 2'b00, 1, 0, 0, 3'd1, 4'b0000, 0, 0, 4'b1101);
    tbl[9]  = mk(4'hD, 2'b00, 1, 0, 0, 3'd1, 4'b0000, 1, 0, 4'b1101);
    tbl[10] = mk(4'hE, 2'b11, 0, 0, 0, 3'd1, 4'b0000, 1, 0, 4'b0000);
    tbl[11] = mk(4'hE, 2'b01, 0, 0, 0, 3'd1, 4'b1111, 1, 0, 4'b0011);
    tbl[12] = mk(4'hE, 2'b00, 1, 0, 0, 3'd1, 4'b1111, 1, 0, 4'b0011);
    tbl[13] = mk(4'hE, 2'b00, 1, 0, 0, 3'd0, 4'b1111, 1, 0, 4'b0011);
    tbl[14] = mk(4'h2, 2'b00, 1, 0, 0, 3'd1, 4'b0000, 1, 0, 4'b0011);
    tbl[15] = mk(4'h3, 2'b00, 1, 0, 0, 3'd1, 4'b0000, 0, 0, 4'b0011);
    tbl[16] = mk(4'h8, 2'b00, 0, 1, 0, 3'd1, 4'b0000, 1, 0, 4'b0011);
    tbl[17] = mk(4'h9, 2'b00, 0, 1, 0, 3'd1, 4'b0000, 0, 0, 4'b0011);
    tbl[18] = mk(4'h6, 2'b00, 0, 0, 1, 3'd1, 4'b0000, 1, 0, 4'b0011);
    tbl[19] = mk(4'h7, 2'b00, 0, 0, 1, 3'd1, 4'b0000, 0, 0, 4'b0011);
    tbl[20] = mk(4'h4, 2'b00, 1, 0, 0, 3'd1, 4'b0000, 0, 0, 4'b0011);
    tbl[21] = mk(4'h5, 2'b00, 1, 0, 0, 3'd1, 4'b0000, 1, 0, 4'b0011);
    tbl[22] = mk(4'hE, 2'b10, 0, 0, 0, 3'd7, 4'b1111, 1, 0, 4'b1111);
    tbl[23] = mk(4'h0, 2'b00, 1, 0, 0, 3'd1, 4'b0000, 1, 0, 4'b1111);
    tbl[24] = mk(4'h8, 2'b00, 1, 0, 0, 3'd1, 4'b0000, 0, 0, 4'b1111);
    tbl[25] = mk(4'hF, 2'b11, 1, 0, 0, 3'd1, 4'b0000, 0, 1, 4'b1111);

    reset = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_flags", 8'(flags), 8'h00);
    chk("rst_strobes", 8'({reg_write, mem_write, pc_src, done, executed, illegal}), 8'h00);
    reset = 1;
    @(negedge clk);
    chk("rst_ready", 8'(issue_ready), 8'd1);

    for (int i = 0; i < 26; i++) run(i, tbl[i]);

    // flush in IDLE blocks acceptance
    flush = 1;
    #1 chk("idle_flush_ready", 8'(issue_ready), 8'd0);
    @(negedge clk);
    flush = 0;

    // flush in the 3rd EXEC cycle of a 5-cycle instruction
    v = mk(4'hE, 2'b11, 1, 1, 1, 3'd5, 4'b0000, 1, 0, 4'b1111);
    issue(v);
    repeat (3) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    #1 chk("flush_ready", 8'(issue_ready), 8'd1);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      seen |= done | reg_write | mem_write | pc_src;
      @(negedge clk);
    end
    chk("flush_no_retire", 8'(seen), 8'd0);
    chk("flush_flags", 8'(flags), 8'hF);
    idle_inputs();

    // back-to-back: accepts spaced N+3 apart with valid held high
    cond = 4'hE; flag_w = 2'b00; exec_cycles = 3'd2; issue_valid = 1;
    for (int c = 0; c < 16; c++) begin
      if (issue_ready) acc.push_back(c);
      @(negedge clk);
    end
    issue_valid = 0;
    k = 0;
    while (!issue_ready && k < 20) begin @(negedge clk); k++; end
    chk("b2b_count", 8'(acc.size() >= 3), 8'd1);
    if (acc.size() >= 3) begin
      chk("b2b_gap0", 8'(acc[1] - acc[0]), 8'd5);
      chk("b2b_gap1", 8'(acc[2] - acc[1]), 8'd5);
    end
    idle_inputs();

    // asynchronous reset mid-EXEC
    v = mk(4'hE, 2'b11, 1, 0, 0, 3'd5, 4'b0000, 1, 0, 4'b0000);
    issue(v);
    repeat (2) @(negedge clk);
    #2 reset = 0;
    #1 chk("arst_exec_flags", 8'(flags), 8'h00);
    chk("arst_exec_ready", 8'(issue_ready), 8'd1);
    @(negedge clk);
    reset = 1;
    idle_inputs();
    @(negedge clk);

    // asynchronous reset while COMMIT outputs are high
    v = mk(4'hE, 2'b11, 1, 0, 0, 3'd1, 4'b0110, 1, 0, 4'b0110);
    issue(v);
    k = 1;
    while (!done && k <= 20) begin @(negedge clk); k++; end
    chk("commit_pre_rw", 8'({reg_write, done, executed}), 8'h07);
    chk("commit_pre_flags", 8'(flags), 8'h06);
    #2 reset = 0;
    #1 chk("arst_commit_out", 8'({reg_write, mem_write, pc_src, done, executed, illegal}), 8'h00);
    chk("arst_commit_flags", 8'(flags), 8'h00);
    @(negedge clk);
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
